// File: rtl/alu_divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package alu_divider_pkg;

   localparam int unsigned SIZE_DEF = 64;

   // Divider control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Iteration counter width; holds SIZE-1 down to 0
   function automatic int unsigned cnt_width(input int unsigned size);
      return $clog2(size);
   endfunction

endpackage

// File: rtl/alu_divider_if.sv
// Request/result bundle between the ALU issue logic and the divider.
interface alu_divider_if
   import alu_divider_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF
);

   logic            start;
   logic            is_signed;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] quotient;
   logic [SIZE-1:0] remainder;
   logic            div_by_zero;
   logic            overflow;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );

endinterface

// File: rtl/alu_div_step.sv
// One restoring radix-2 iteration on unsigned magnitudes.
module alu_div_step
   import alu_divider_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF
) (
   input  logic [SIZE-1:0] i_rem,
   input  logic [SIZE-1:0] i_dvd,
   input  logic [SIZE-1:0] i_divisor,
   output logic [SIZE-1:0] o_rem_next,
   output logic [SIZE-1:0] o_dvd_next,
   output logic            o_q_bit
);

   logic [SIZE:0]   w_shift;
   logic [SIZE-1:0] w_trial;

   // Shift dividend MSB into remainder; keep the trial difference only when it does not borrow
   always_comb begin
      w_shift    = {i_rem, i_dvd[SIZE-1]};
      // Compare at SIZE+1 bits; a kept difference is below the divisor so SIZE bits suffice
      o_q_bit    = (w_shift >= {1'b0, i_divisor});
      w_trial    = w_shift[SIZE-1:0] - i_divisor;
      o_rem_next = o_q_bit ? w_trial : w_shift[SIZE-1:0];
      o_dvd_next = {i_dvd[SIZE-2:0], 1'b0};
   end

endmodule

// File: rtl/alu_divider.sv
// Sequential DIV/DIVU unit: magnitude restoring divide plus sign fix-up, SIZE+1 cycles.
module alu_divider
   import alu_divider_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   alu_divider_if.slave  bus
);

   localparam int unsigned CNT_W = cnt_width(SIZE);

   state_t          r_state;
   state_t          w_state_next;
   logic            w_accept;

   logic [CNT_W-1:0] r_cnt;
   logic [SIZE-1:0] r_rem;
   logic [SIZE-1:0] r_dvd;
   logic [SIZE-1:0] r_div;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_dbz_case;
   logic            r_ovf_case;

   logic            r_busy;
   logic            r_done;
   logic [SIZE-1:0] r_quotient;
   logic [SIZE-1:0] r_remainder;
   logic            r_dbz;
   logic            r_ovf;

   logic            w_a_neg;
   logic            w_b_neg;
   logic [SIZE-1:0] w_a_mag;
   logic [SIZE-1:0] w_b_mag;
   logic [SIZE-1:0] w_min;
   logic [SIZE-1:0] w_rem_next;
   logic [SIZE-1:0] w_dvd_next;
   logic            w_q_bit;

   // Operand signs and magnitudes; |most-negative| is still representable unsigned
   always_comb begin
      w_min   = {1'b1, {(SIZE-1){1'b0}}};
      w_a_neg = bus.is_signed & bus.a[SIZE-1];
      w_b_neg = bus.is_signed & bus.b[SIZE-1];
      w_a_mag = w_a_neg ? SIZE'(-bus.a) : bus.a;
      w_b_mag = w_b_neg ? SIZE'(-bus.b) : bus.b;
   end

   alu_div_step #(.SIZE(SIZE)) u_step (
      .i_rem      (r_rem),
      .i_dvd      (r_dvd),
      .i_divisor  (r_div),
      .o_rem_next (w_rem_next),
      .o_dvd_next (w_dvd_next),
      .o_q_bit    (w_q_bit)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state and request acceptance
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == '0) w_state_next = ST_FIX;
         end
         ST_FIX: w_state_next = ST_DONE;
         ST_DONE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Operand capture, iteration datapath, fix-up and registered results
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_dvd       <= '0;
         r_div       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_dbz_case  <= 1'b0;
         r_ovf_case  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_busy <= (w_state_next == ST_RUN) || (w_state_next == ST_FIX);
         r_done <= (w_state_next == ST_DONE);
         if (w_accept) begin
            r_rem      <= '0;
            r_dvd      <= w_a_mag;
            r_div      <= w_b_mag;
            r_cnt      <= CNT_W'(SIZE - 1);
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_dbz_case <= (bus.b == '0);
            r_ovf_case <= bus.is_signed && (bus.a == w_min) && (bus.b == '1);
         end else if (r_state == ST_RUN) begin
            r_rem <= w_rem_next;
            // Dividend shifts left; its vacated LSB collects the new quotient bit
            r_dvd <= w_dvd_next | SIZE'(w_q_bit);
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
         end else if (r_state == ST_FIX) begin
            // Zero divisor: remainder already returns to a after the sign fix; only quotient is forced
            r_quotient  <= r_dbz_case ? '1 : (r_neg_q ? SIZE'(-r_dvd) : r_dvd);
            r_remainder <= r_neg_r ? SIZE'(-r_rem) : r_rem;
            r_dbz       <= r_dbz_case;
            r_ovf       <= r_ovf_case;
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;
   assign bus.overflow    = r_ovf;

endmodule
